class_score_sequencer: RTL and testbench
========================================

CLASS_SCORE_SEQUENCER -- requirements
Module: class_score_sequencer

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 1280, number of voxel-bin cells scanned (5 bins x 256).
REQ-002 SHALL have parameter NUM_CLASSES, default 4, number of class weight ROMs.
REQ-003 SHALL have parameter WEIGHT_BITS, default 8, signed weight width.
REQ-004 SHALL have parameter COUNT_BITS, default 8, unsigned voxel-count width.
REQ-005 SHALL have parameter ACC_BITS, default 28; must be at least COUNT_BITS+WEIGHT_BITS+clog2(NUM_CELLS).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, request a classification scan.
REQ-010 SHALL have port abort, input, 1, cancel the scan in progress.
REQ-011 SHALL have port cell_addr, output, clog2(NUM_CELLS), address shared by the feature memory and all weight ROMs.
REQ-012 SHALL have port feat_in, input, COUNT_BITS, unsigned voxel count; 1-cycle synchronous read latency.
REQ-013 SHALL have port weight_in, input, NUM_CLASSES*WEIGHT_BITS; signed; class k at [k*WEIGHT_BITS +: WEIGHT_BITS]; 1-cycle latency.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port result_valid, output, 1, result available.
REQ-016 SHALL have port result_ready, input, 1, consumer accepts the result.
REQ-017 SHALL have port result_class, output, clog2(NUM_CLASSES), winning class index.
REQ-018 SHALL have port result_score, output, ACC_BITS, signed score of the winning class.

Function
REQ-019 SHALL implement the FSM states IDLE, SCAN, DRAIN, ARGMAX and HOLD.
REQ-020 SHALL accept start only in IDLE; acceptance clears all NUM_CLASSES accumulators and cell_addr, and moves to SCAN.
REQ-021 SHALL, in SCAN, present cell_addr = 0..NUM_CELLS-1 on consecutive cycles, one address per cycle with no gaps.
REQ-022 SHALL delay an issue-valid flag by 1 cycle; when set, add feat_in (zero-extended) x weight_k (sign-extended) to acc_k for every class in that cycle.
REQ-023 SHALL move from SCAN to DRAIN after address NUM_CELLS-1; DRAIN lasts 1 cycle to absorb the last product; cell_addr holds at NUM_CELLS-1 and does not wrap.
REQ-024 SHALL, in ARGMAX, compare one class per cycle over NUM_CLASSES cycles with a signed compare; a later class replaces the best only on strictly greater, so ties go to the lower index.
REQ-025 SHALL register result_class and result_score on leaving ARGMAX and enter HOLD with result_valid=1, exactly NUM_CLASSES+NUM_CELLS+2 cycles after the start-accept edge (1286 at defaults).
REQ-026 SHALL, in HOLD, keep result_valid, result_class and result_score stable until result_valid and result_ready are both high; it then returns to IDLE next cycle with result_valid=0.
REQ-027 SHALL ignore start outside IDLE, including in the handshake cycle.
REQ-028 SHALL make abort in SCAN, DRAIN or ARGMAX return to IDLE next cycle, with no result_valid and the previous result outputs unchanged; abort is ignored in IDLE and HOLD.
REQ-029 SHALL make abort win over the end-of-scan transition when both occur in the same cycle.
REQ-030 SHALL never overflow an accumulator, given the width rule in REQ-005; no saturation logic.

Reset
REQ-031 SHALL, on rst, go to IDLE, with cell_addr=0, busy=0, result_valid=0, result_class=0, result_score=0, accumulators=0 and the delay flag=0.
REQ-032 SHALL, on rst asserted mid-scan, discard all partial sums; a start in the cycle after reset releases is accepted normally.

Structure
REQ-033 SHALL place NUM_CLASSES, the class index enum (UP=0, DOWN=1, LEFT=2, RIGHT=3) and the FSM state enum in a shared package, gesture_pkg.
REQ-034 SHALL implement one sub-module, class_mac_lane (one signed accumulator per class), instantiated NUM_CLASSES times.

Verification
REQ-035 SHALL cover: feat_in=0 everywhere, start -> result_valid at start+1286, result_class=0, result_score=0.
REQ-036 SHALL cover: real class ROMs, feat=1 at cells with cy<8 in all 5 bins -> result_class=0 (UP), result_score=34560.
REQ-037 SHALL cover: feat=255 and all weights -128 -> result_score=-41779200 with no wrap, result_class=0.
REQ-038 SHALL cover: result_ready held low for 10 cycles in HOLD -> outputs stable; ready high -> IDLE next cycle, busy=0.
REQ-039 SHALL cover: start pulsed during SCAN ignored; abort at cell_addr=500 -> IDLE next cycle, result_valid never asserted.
REQ-040 SHALL cover: rst at cell_addr=700 -> all outputs 0 next cycle; a fresh start then completes correctly.

Source files
------------

// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture classifier: class count, class
// index names and the scan sequencer state encoding.
package gesture_pkg;

    localparam int NUM_CLASSES       = 4;
    localparam int NUM_CELLS_DEFAULT = 1280;

    typedef enum logic [1:0] {
        CLS_UP    = 2'd0,
        CLS_DOWN  = 2'd1,
        CLS_LEFT  = 2'd2,
        CLS_RIGHT = 2'd3
    } class_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/class_mac_lane.sv
// One class accumulator: adds count x weight each enabled cycle.
// The count is unsigned, the weight signed; both are widened to the
// accumulator width before multiplying, so the product is exact.
module class_mac_lane #(
    parameter int COUNT_BITS  = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int ACC_BITS    = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic [COUNT_BITS-1:0]      feat_in,
    input  logic signed [WEIGHT_BITS-1:0] weight_in,
    output logic signed [ACC_BITS-1:0] acc
);

    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic signed [ACC_BITS-1:0] feat_ext, weight_ext, prod;

    // Widen operands, form the product, and pick the next sum (clear beats add).
    always_comb begin
        feat_ext   = {{(ACC_BITS-COUNT_BITS){1'b0}}, feat_in};
        weight_ext = {{(ACC_BITS-WEIGHT_BITS){weight_in[WEIGHT_BITS-1]}}, weight_in};
        prod       = feat_ext * weight_ext;
        acc_d      = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/class_score_sequencer.sv
// Scans every voxel-bin cell once, accumulating a weighted score per class,
// then picks the best class (ties to the lower index) and holds it on a
// valid/ready output.
// Result handshake: result_valid rises in HOLD and, together with
// result_class/result_score, stays stable until a cycle where
// result_valid && result_ready; the transfer happens on that edge.
module class_score_sequencer #(
    parameter int NUM_CELLS   = 1280,
    parameter int NUM_CLASSES = gesture_pkg::NUM_CLASSES,
    parameter int WEIGHT_BITS = 8,
    parameter int COUNT_BITS  = 8,
    parameter int ACC_BITS    = 28,
    localparam int ADDR_BITS  = $clog2(NUM_CELLS),
    localparam int CLS_BITS   = $clog2(NUM_CLASSES)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    output logic [ADDR_BITS-1:0]               cell_addr,
    input  logic [COUNT_BITS-1:0]              feat_in,
    input  logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_in,
    output logic                               busy,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [CLS_BITS-1:0]                result_class,
    output logic signed [ACC_BITS-1:0]         result_score
);

    import gesture_pkg::*;

    // ARGMAX walks indices 0..NUM_CLASSES-1, then one extra step to register the result.
    localparam int ARG_BITS = $clog2(NUM_CLASSES + 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CELLS - 1);
    localparam logic [ARG_BITS-1:0]  ARG_LAST  = ARG_BITS'(NUM_CLASSES);

    state_e                     state_q, state_d;
    logic [ADDR_BITS-1:0]       addr_q, addr_d;
    logic                       issue_q, issue_d;
    logic [ARG_BITS-1:0]        arg_idx_q, arg_idx_d;
    logic [CLS_BITS-1:0]        best_class_q, best_class_d;
    logic signed [ACC_BITS-1:0] best_score_q, best_score_d;
    logic [CLS_BITS-1:0]        res_class_q, res_class_d;
    logic signed [ACC_BITS-1:0] res_score_q, res_score_d;
    logic signed [ACC_BITS-1:0] cur_score;
    logic signed [ACC_BITS-1:0] acc [NUM_CLASSES];
    logic                       clear_acc;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        class_mac_lane #(
            .COUNT_BITS  (COUNT_BITS),
            .WEIGHT_BITS (WEIGHT_BITS),
            .ACC_BITS    (ACC_BITS)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear_acc),
            .en        (issue_q),
            .feat_in   (feat_in),
            .weight_in (weight_in[k*WEIGHT_BITS +: WEIGHT_BITS]),
            .acc       (acc[k])
        );
    end

    // Select the accumulator currently being compared in ARGMAX.
    always_comb begin
        cur_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (arg_idx_q == ARG_BITS'(k)) begin
                cur_score = acc[k];
            end
        end
    end

    // Sequencer next-state logic; abort is checked before end-of-scan so it wins.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_d      = (state_q == ST_SCAN);
        arg_idx_d    = arg_idx_q;
        best_class_d = best_class_q;
        best_score_d = best_score_q;
        res_class_d  = res_class_q;
        res_score_d  = res_score_q;
        clear_acc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    addr_d    = '0;
                    clear_acc = 1'b1;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_BITS'(1);
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_ARGMAX;
                    arg_idx_d = '0;
                end
            end
            ST_ARGMAX: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (arg_idx_q == ARG_LAST) begin
                    res_class_d = best_class_q;
                    res_score_d = best_score_q;
                    state_d     = ST_HOLD;
                end else begin
                    if ((arg_idx_q == '0) || (cur_score > best_score_q)) begin
                        best_class_d = CLS_BITS'(arg_idx_q);
                        best_score_d = cur_score;
                    end
                    arg_idx_d = arg_idx_q + ARG_BITS'(1);
                end
            end
            ST_HOLD: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            issue_q      <= 1'b0;
            arg_idx_q    <= '0;
            best_class_q <= '0;
            best_score_q <= '0;
            res_class_q  <= '0;
            res_score_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_q      <= issue_d;
            arg_idx_q    <= arg_idx_d;
            best_class_q <= best_class_d;
            best_score_q <= best_score_d;
            res_class_q  <= res_class_d;
            res_score_q  <= res_score_d;
        end
    end

    assign cell_addr    = addr_q;
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_HOLD);
    assign result_class = res_class_q;
    assign result_score = res_score_q;

endmodule

// File: tb/tb_class_score_sequencer.sv
// Bench for class_score_sequencer: table of hand-derived scan cases,
// randomized scans scored by an array-based model, and hand sequences
// for hold/handshake, abort and mid-scan reset.
module tb_class_score_sequencer;

    localparam int NUM_CELLS   = 1280;
    localparam int NUM_CLASSES = 4;
    localparam int WEIGHT_BITS = 8;
    localparam int COUNT_BITS  = 8;
    localparam int ACC_BITS    = 28;
    localparam int ADDR_BITS   = 11;
    localparam int CLS_BITS    = 2;
    localparam int LATENCY     = NUM_CELLS + NUM_CLASSES + 2;
    localparam int W           = CLS_BITS + ACC_BITS;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst, start, abort, result_ready;
    logic [ADDR_BITS-1:0] cell_addr;
    logic [COUNT_BITS-1:0] feat_in;
    logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_in;
    logic busy, result_valid;
    logic [CLS_BITS-1:0] result_class;
    logic [ACC_BITS-1:0] result_score;

    always #5 clk = ~clk;

    class_score_sequencer #(
        .NUM_CELLS   (NUM_CELLS),
        .NUM_CLASSES (NUM_CLASSES),
        .WEIGHT_BITS (WEIGHT_BITS),
        .COUNT_BITS  (COUNT_BITS),
        .ACC_BITS    (ACC_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cell_addr    (cell_addr),
        .feat_in      (feat_in),
        .weight_in    (weight_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score)
    );

    // Feature memory and class ROMs with one-cycle synchronous read.
    logic [COUNT_BITS-1:0]         feat_mem [NUM_CELLS];
    logic signed [WEIGHT_BITS-1:0] w_mem [NUM_CLASSES][NUM_CELLS];

    always @(posedge clk) begin
        feat_in <= feat_mem[cell_addr];
        for (int k = 0; k < NUM_CLASSES; k++) begin
            weight_in[k*WEIGHT_BITS +: WEIGHT_BITS] <= w_mem[k][cell_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Gesture ROM: UP favours top rows, DOWN bottom rows, LEFT left columns, RIGHT right columns.
    function automatic int rom_weight(input int k, input int c);
        int cy;
        int cx;
        bit pos;
        cy = (c % 256) / 16;
        cx = c % 16;
        case (k)
            0:       pos = (cy < 8);
            1:       pos = (cy >= 8);
            2:       pos = (cx < 8);
            default: pos = (cx >= 8);
        endcase
        return pos ? 54 : -54;
    endfunction

    task automatic load_table_pattern(input int fp, input int wp);
        int cy;
        int cx;
        for (int c = 0; c < NUM_CELLS; c++) begin
            cy = (c % 256) / 16;
            cx = c % 16;
            case (fp)
                0:       feat_mem[c] = 8'd0;
                1:       feat_mem[c] = (cy < 8) ? 8'd1 : 8'd0;
                2:       feat_mem[c] = 8'd255;
                3:       feat_mem[c] = (cy >= 8) ? 8'd1 : 8'd0;
                4:       feat_mem[c] = (cx < 8) ? 8'd1 : 8'd0;
                default: feat_mem[c] = (cx >= 8) ? 8'd1 : 8'd0;
            endcase
            for (int k = 0; k < NUM_CLASSES; k++) begin
                w_mem[k][c] = (wp == 0) ? 8'(rom_weight(k, c)) : -8'sd128;
            end
        end
    endtask

    // mode 0: fully random; mode 1: every class shares one weight set (full tie).
    task automatic load_random(input int mode);
        for (int c = 0; c < NUM_CELLS; c++) begin
            feat_mem[c] = 8'($urandom_range(0, 255));
            for (int k = 0; k < NUM_CLASSES; k++) begin
                w_mem[k][c] = 8'($urandom_range(0, 255));
            end
            if (mode == 1) begin
                for (int k = 1; k < NUM_CLASSES; k++) begin
                    w_mem[k][c] = w_mem[0][c];
                end
            end
        end
    endtask

    // Reference model: straight dot product per class, then first-strict-maximum.
    task automatic push_model();
        longint s [NUM_CLASSES];
        int best;
        logic [W-1:0] e;
        for (int k = 0; k < NUM_CLASSES; k++) s[k] = 0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                s[k] += longint'(feat_mem[c]) * longint'(w_mem[k][c]);
            end
        end
        best = 0;
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (s[k] > s[best]) best = k;
        end
        e[W-1 -: CLS_BITS]  = CLS_BITS'(best);
        e[ACC_BITS-1:0]     = ACC_BITS'(s[best]);
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks (all entered and left at a negedge) ----------------
    task automatic start_scan();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_addr(input int target);
        int n;
        n = 0;
        while (cell_addr != ADDR_BITS'(target) && n < 3000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_addr: address %0d never seen, got %0d", target, cell_addr);
        end
    endtask

    task automatic run_scan(input string name, input int hold, input bit hs_start);
        int cyc;
        bit seen;
        logic [W-1:0] e;
        start_scan();
        check({name, " busy"}, busy, 1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < LATENCY + 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        e = exp_q.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s latency: no result_valid after %0d cycles, required %0d", name, cyc, LATENCY);
            return;
        end
        check({name, " latency"}, cyc, LATENCY);
        check({name, " class"}, result_class, e[W-1 -: CLS_BITS]);
        check({name, " score"}, longint'($signed(result_score)), longint'($signed(e[ACC_BITS-1:0])));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, " hold valid"}, result_valid, 1);
            check({name, " hold class"}, result_class, e[W-1 -: CLS_BITS]);
            check({name, " hold score"}, longint'($signed(result_score)), longint'($signed(e[ACC_BITS-1:0])));
        end
        result_ready = 1'b1;
        start        = hs_start;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        start        = 1'b0;
        check({name, " valid drop"}, result_valid, 0);
        check({name, " idle"}, busy, 0);
        if (hs_start) begin
            @(posedge clk);
            @(negedge clk);
            check({name, " handshake start ignored"}, busy, 0);
        end
        last_exp = e;
    endtask

    task automatic check_no_result(input string name, input int cycles);
        int seen_valid;
        int seen_busy;
        seen_valid = 0;
        seen_busy  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (result_valid) seen_valid++;
            if (busy) seen_busy++;
        end
        check({name, " no valid"}, seen_valid, 0);
        check({name, " stays idle"}, seen_busy, 0);
    endtask

    task automatic check_aborted(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " valid"}, result_valid, 0);
        check({name, " class kept"}, result_class, last_exp[W-1 -: CLS_BITS]);
        check({name, " score kept"}, longint'($signed(result_score)), longint'($signed(last_exp[ACC_BITS-1:0])));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string  name;
        int     fp;
        int     wp;
        int     exp_class;
        longint exp_score;
        int     hold;
        bit     hs_start;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] e;
        int offs [2];

        vecs[0] = '{"zero_feat",  0, 0, 0, 0,         0,  1'b0};
        vecs[1] = '{"upper_half", 1, 0, 0, 34560,     0,  1'b0};
        vecs[2] = '{"sat_neg",    2, 1, 0, -41779200, 0,  1'b0};
        vecs[3] = '{"lower_half", 3, 0, 1, 34560,     0,  1'b0};
        vecs[4] = '{"left_half",  4, 0, 2, 34560,     10, 1'b1};
        vecs[5] = '{"right_half", 5, 0, 3, 34560,     0,  1'b0};
        vecs[6] = '{"all_tie",    2, 0, 0, 0,         0,  1'b0};
        vecs[7] = '{"zero_neg",   0, 1, 0, 0,         0,  1'b0};

        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b0;
        last_exp     = '0;
        load_table_pattern(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset cell_addr", cell_addr, 0);
        check("reset busy", busy, 0);
        check("reset valid", result_valid, 0);
        check("reset class", result_class, 0);
        check("reset score", result_score, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Table-driven scans.
        for (int i = 0; i < 8; i++) begin
            load_table_pattern(vecs[i].fp, vecs[i].wp);
            e[W-1 -: CLS_BITS] = CLS_BITS'(vecs[i].exp_class);
            e[ACC_BITS-1:0]    = ACC_BITS'(vecs[i].exp_score);
            exp_q.push_back(e);
            run_scan(vecs[i].name, vecs[i].hold, vecs[i].hs_start);
        end

        // Randomized scans against the model.
        for (int i = 0; i < 4; i++) begin
            load_random((i == 2) ? 1 : 0);
            push_model();
            run_scan("random", (i == 1) ? 3 : 0, 1'b0);
        end

        // Start during SCAN ignored, abort at address 500.
        start_scan();
        wait_addr(100);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("scan start ignored addr", cell_addr, 101);
        wait_addr(500);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_aborted("abort@500");
        check_no_result("abort@500", LATENCY + 20);

        // Abort on the last SCAN cycle beats the move to DRAIN.
        start_scan();
        wait_addr(NUM_CELLS - 1);
        check("last addr in scan busy", busy, 1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_aborted("abort@end");
        check_no_result("abort@end", 20);

        // Abort in DRAIN and in the middle of ARGMAX.
        offs[0] = NUM_CELLS;
        offs[1] = NUM_CELLS + 3;
        for (int j = 0; j < 2; j++) begin
            start_scan();
            repeat (offs[j]) begin
                @(posedge clk);
                @(negedge clk);
            end
            abort = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            check_aborted((j == 0) ? "abort drain" : "abort argmax");
            check_no_result((j == 0) ? "abort drain" : "abort argmax", 20);
        end

        // Leave a nonzero result behind, then reset in the middle of a scan.
        load_table_pattern(5, 0);
        push_model();
        run_scan("pre_reset", 0, 1'b0);
        load_random(0);
        start_scan();
        wait_addr(700);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midscan reset cell_addr", cell_addr, 0);
        check("midscan reset busy", busy, 0);
        check("midscan reset valid", result_valid, 0);
        check("midscan reset class", result_class, 0);
        check("midscan reset score", result_score, 0);
        rst = 1'b0;
        push_model();
        run_scan("after_reset", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
